// File: rtl/mem_access_ctrl_if.sv
// Request, response and memory-pin bundle for mem_access_ctrl; slave = controller side.
// Latency/backpressure are set by the controller: valid/ready on requests and response, CS-qualified memory pins.
interface mem_access_ctrl_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic                 if_req_valid;
  logic [ADDR_BITS-1:0] if_req_addr;
  logic                 if_req_ready;
  logic                 d_req_valid;
  logic                 d_req_we;
  logic [ADDR_BITS-1:0] d_req_addr;
  logic [DATA_BITS-1:0] d_req_wdata;
  logic                 d_req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_src;
  logic [DATA_BITS-1:0] rsp_rdata;
  logic                 rsp_err;
  logic                 mem_cs;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic [DATA_BITS-1:0] mem_rdata;
  logic                 mem_err;

  modport slave (
    input  if_req_valid, if_req_addr, d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    input  rsp_ready, mem_rdata, mem_err,
    output if_req_ready, d_req_ready, rsp_valid, rsp_src, rsp_rdata, rsp_err,
    output mem_cs, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req_valid, if_req_addr, d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    output rsp_ready, mem_rdata, mem_err,
    input  if_req_ready, d_req_ready, rsp_valid, rsp_src, rsp_rdata, rsp_err,
    input  mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Round-robin fetch/data arbiter sequencing one memory access at a time; accept-to-rsp_valid 2 edges, 4 cycles min per txn.
// Backpressure: rsp_ready low holds the response in RESP and no request is accepted until it is taken.
module mem_access_ctrl #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int ROM_SIZE  = 128
) (
  input  logic               CLK,
  input  logic               RESET,
  mem_access_ctrl_if.slave   bus,
  output logic [7:0]         err_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [ADDR_BITS:0] ROM_LIM = ROM_SIZE[ADDR_BITS:0];

  state_t state;
  logic   last_d;
  logic   cur_we;
  logic   cur_src;
  logic   grant_if;
  logic   grant_d;
  logic   rom_wr;

  // Fetch wins unless data is also asking and fetch had the previous grant.
  always_comb begin
    grant_if = bus.if_req_valid && (!bus.d_req_valid || last_d);
    grant_d  = bus.d_req_valid && !grant_if;
    rom_wr   = cur_we && ({1'b0, bus.mem_addr} < ROM_LIM);
  end

  assign bus.if_req_ready = (state == IDLE) && !RESET && grant_if;
  assign bus.d_req_ready  = (state == IDLE) && !RESET && grant_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      last_d        <= 1'b1;
      cur_we        <= 1'b0;
      cur_src       <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_src   <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.mem_cs    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      err_cnt       <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_if) begin
            bus.mem_cs   <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= bus.if_req_addr;
            cur_we       <= 1'b0;
            cur_src      <= 1'b0;
            last_d       <= 1'b0;
            state        <= ISSUE;
          end else if (grant_d) begin
            bus.mem_cs    <= 1'b1;
            bus.mem_we    <= bus.d_req_we;
            bus.mem_addr  <= bus.d_req_addr;
            bus.mem_wdata <= bus.d_req_wdata;
            cur_we        <= bus.d_req_we;
            cur_src       <= 1'b1;
            last_d        <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          bus.mem_cs <= 1'b0;
          bus.mem_we <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          // A write below the ROM boundary must come back flagged by the memory.
          assert (!rom_wr || bus.mem_err);
          bus.rsp_valid <= 1'b1;
          bus.rsp_src   <= cur_src;
          bus.rsp_rdata <= cur_we ? '0 : bus.mem_rdata;
          bus.rsp_err   <= bus.mem_err;
          if (bus.mem_err && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
          state <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized and directed bench for mem_access_ctrl with a transaction-level reference model and memory stub.
module tb_mem_access_ctrl;
  localparam int AB = 8;
  localparam int DB = 8;
  localparam logic [7:0] ROM_B = 8'd128;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] err_cnt;

  always #5 CLK = ~CLK;

  mem_access_ctrl_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  mem_access_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB), .ROM_SIZE(128)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus), .err_cnt(err_cnt)
  );

  // Memory stub: acts on the edge ending a CS cycle, refuses ROM writes and flags them.
  logic [7:0] mem [256];
  always @(posedge CLK) begin
    if (bus.mem_cs) begin
      bus.mem_err   <= bus.mem_we && (bus.mem_addr < ROM_B);
      bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_we && (bus.mem_addr >= ROM_B)) mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  // Reference model: memory contents plus "cycles since accept" of the one outstanding transaction.
  logic [7:0] shadow [256];
  bit         m_busy = 0;
  int         m_k = 0;
  int         m_last_src = 1;
  int         m_cnt = 0;
  logic [7:0] m_addr = 8'h00;
  bit         t_src, t_we;
  logic [7:0] t_addr, t_wdata;
  logic [7:0] p_rdata;
  bit         p_err;
  bit         r_src = 0;
  logic [7:0] r_rdata = 8'h00;
  bit         r_err = 0;
  bit         acc_if, acc_d;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int gtr[$];
  int rsp_cyc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Called at a negedge with inputs driven: compare this cycle, then advance the model over the next edge.
  task automatic step();
    int win;
    bit e_cs;
    #1;
    if (bus.if_req_valid && bus.d_req_valid) win = 1 - m_last_src;
    else if (bus.if_req_valid)               win = 0;
    else if (bus.d_req_valid)                win = 1;
    else                                     win = -1;
    e_cs = m_busy && (m_k == 1);

    chk("if_req_ready", bus.if_req_ready, !RESET && !m_busy && (win == 0));
    chk("d_req_ready",  bus.d_req_ready,  !RESET && !m_busy && (win == 1));
    chk("mem_cs",   bus.mem_cs, e_cs);
    chk("mem_we",   bus.mem_we, e_cs && t_we);
    chk("mem_addr", bus.mem_addr, m_addr);
    if (e_cs && t_we) chk("mem_wdata", bus.mem_wdata, t_wdata);
    chk("rsp_valid", bus.rsp_valid, m_busy && (m_k >= 3));
    if (m_busy && (m_k >= 3)) begin
      chk("rsp_src",   bus.rsp_src, r_src);
      chk("rsp_rdata", bus.rsp_rdata, r_rdata);
      chk("rsp_err",   bus.rsp_err, r_err);
    end
    chk("err_cnt", err_cnt, m_cnt);

    if (bus.if_req_ready) gtr.push_back(0);
    if (bus.d_req_ready)  gtr.push_back(1);
    if (bus.rsp_valid && bus.rsp_ready) rsp_cyc.push_back(cyc);

    acc_if = 0;
    acc_d  = 0;
    if (e_cs) begin
      p_err   = t_we && (t_addr < ROM_B);
      p_rdata = t_we ? 8'h00 : shadow[t_addr];
      if (t_we && !p_err) shadow[t_addr] = t_wdata;
    end
    if (RESET) begin
      m_busy = 0; m_k = 0; m_last_src = 1; m_cnt = 0; m_addr = 8'h00;
      r_src = 0; r_rdata = 8'h00; r_err = 0;
    end else if (!m_busy) begin
      if (win >= 0) begin
        m_busy = 1; m_k = 1; m_last_src = win;
        t_src   = (win == 1);
        t_we    = t_src ? bus.d_req_we : 1'b0;
        t_addr  = t_src ? bus.d_req_addr : bus.if_req_addr;
        t_wdata = bus.d_req_wdata;
        m_addr  = t_addr;
        acc_if  = !t_src;
        acc_d   = t_src;
      end
    end else if (m_k == 1) begin
      m_k = 2;
    end else if (m_k == 2) begin
      r_src = t_src; r_rdata = p_rdata; r_err = p_err;
      if (p_err && m_cnt < 255) m_cnt++;
      m_k = 3;
    end else if (bus.rsp_ready) begin
      m_busy = 0; m_k = 0;
    end
    cyc++;
    @(negedge CLK);
  endtask

  task automatic do_req(input bit src, input bit we, input logic [7:0] a, input logic [7:0] wd, input bit rr);
    int n;
    bit got;
    bus.rsp_ready = rr;
    if (src) begin
      bus.d_req_valid = 1'b1; bus.d_req_we = we; bus.d_req_addr = a; bus.d_req_wdata = wd;
    end else begin
      bus.if_req_valid = 1'b1; bus.if_req_addr = a;
    end
    got = 0;
    n = 0;
    while (!got && n < 20) begin
      step();
      got = src ? acc_d : acc_if;
      n++;
    end
    bus.if_req_valid = 1'b0;
    bus.d_req_valid  = 1'b0;
    chk("accept", got, 1);
    chk("issue_cs", bus.mem_cs, 1);
    chk("issue_we", bus.mem_we, we);
    chk("issue_addr", bus.mem_addr, a);
    n = 0;
    while (!bus.rsp_valid && n < 10) begin
      step();
      n++;
    end
    chk("rsp_latency", n, 2);
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    step();
    chk("rsp_done", bus.rsp_valid, 0);
  endtask

  task automatic pulse_reset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, cnt;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 8'(i) ^ 8'hA0;
      shadow[i] = 8'(i) ^ 8'hA0;
    end
    RESET = 1'b1;
    bus.if_req_valid = 1'b0; bus.if_req_addr = 8'h00;
    bus.d_req_valid = 1'b0; bus.d_req_we = 1'b0; bus.d_req_addr = 8'h00; bus.d_req_wdata = 8'h00;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_mem_cs", bus.mem_cs, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_err_cnt", err_cnt, 0);

    // Fetch from preloaded ROM.
    do_req(0, 0, 8'h05, 8'h00, 1);
    chk("f05_src", bus.rsp_src, 0);
    chk("f05_rdata", bus.rsp_rdata, 8'hA5);
    chk("f05_err", bus.rsp_err, 0);
    finish_rsp();

    // Store then load in RAM.
    do_req(1, 1, 8'h90, 8'h3C, 1);
    chk("st90_src", bus.rsp_src, 1);
    chk("st90_rdata", bus.rsp_rdata, 0);
    chk("st90_err", bus.rsp_err, 0);
    finish_rsp();
    do_req(1, 0, 8'h90, 8'h00, 1);
    chk("ld90_rdata", bus.rsp_rdata, 8'h3C);
    finish_rsp();

    // Store into ROM is flagged and does not stick.
    do_req(1, 1, 8'h10, 8'hEE, 1);
    chk("st10_err", bus.rsp_err, 1);
    chk("st10_err_cnt", err_cnt, 1);
    finish_rsp();
    do_req(1, 0, 8'h10, 8'h00, 1);
    chk("ld10_rdata", bus.rsp_rdata, 8'hB0);
    chk("ld10_err", bus.rsp_err, 0);
    finish_rsp();

    // Response backpressure with both requesters waiting.
    do_req(0, 0, 8'h07, 8'h00, 0);
    bus.if_req_valid = 1'b1; bus.if_req_addr = 8'h40;
    bus.d_req_valid = 1'b1; bus.d_req_we = 1'b0; bus.d_req_addr = 8'h91;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_rsp_valid", bus.rsp_valid, 1);
      chk("stall_rdata", bus.rsp_rdata, 8'hA7);
      chk("stall_if_rdy", bus.if_req_ready, 0);
      chk("stall_d_rdy", bus.d_req_ready, 0);
      chk("stall_cs", bus.mem_cs, 0);
      step();
    end
    bus.if_req_valid = 1'b0;
    bus.d_req_valid  = 1'b0;
    finish_rsp();

    // Both ports continuously valid alternate F, D, F, D.
    pulse_reset();
    gtr.delete();
    rsp_cyc.delete();
    bus.rsp_ready = 1'b1;
    bus.if_req_valid = 1'b1; bus.if_req_addr = 8'h21;
    bus.d_req_valid = 1'b1; bus.d_req_we = 1'b0; bus.d_req_addr = 8'h92;
    for (int i = 0; i < 16; i++) step();
    bus.if_req_valid = 1'b0;
    bus.d_req_valid  = 1'b0;
    chk("rr_grants", gtr.size(), 4);
    for (int i = 0; i < gtr.size() && i < 4; i++) chk("rr_order", gtr[i], i % 2);
    chk("rr_rsps", rsp_cyc.size(), 4);
    for (int i = 1; i < rsp_cyc.size(); i++) chk("rr_gap", rsp_cyc[i] - rsp_cyc[i-1], 4);
    n = 0;
    while (m_busy && n < 10) begin step(); n++; end

    // Reset during ISSUE of a store drops it.
    bus.rsp_ready = 1'b1;
    bus.d_req_valid = 1'b1; bus.d_req_we = 1'b1; bus.d_req_addr = 8'h12; bus.d_req_wdata = 8'h66;
    n = 0;
    acc_d = 0;
    while (!acc_d && n < 20) begin step(); n++; end
    bus.d_req_valid = 1'b0;
    chk("mid_issue_cs", bus.mem_cs, 1);
    pulse_reset();
    chk("mid_cs_after", bus.mem_cs, 0);
    chk("mid_err_cnt", err_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      chk("mid_no_rsp", bus.rsp_valid, 0);
      step();
    end
    do_req(0, 0, 8'h30, 8'h00, 1);
    chk("post_rst_rdata", bus.rsp_rdata, 8'h90);
    finish_rsp();

    // 256 ROM writes saturate err_cnt.
    pulse_reset();
    bus.rsp_ready = 1'b1;
    bus.d_req_valid = 1'b1; bus.d_req_we = 1'b1; bus.d_req_addr = 8'h22; bus.d_req_wdata = 8'h55;
    cnt = 0;
    n = 0;
    while (cnt < 256 && n < 1200) begin
      step();
      if (acc_d) cnt++;
      n++;
    end
    bus.d_req_valid = 1'b0;
    n = 0;
    while (m_busy && n < 10) begin step(); n++; end
    chk("sat_accepts", cnt, 256);
    chk("sat_err_cnt", err_cnt, 255);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (!bus.if_req_valid || acc_if) begin
        bus.if_req_valid = ($urandom_range(0, 2) == 0);
        bus.if_req_addr  = 8'($urandom);
      end
      if (!bus.d_req_valid || acc_d) begin
        bus.d_req_valid = ($urandom_range(0, 2) == 0);
        bus.d_req_we    = 1'($urandom_range(0, 1));
        bus.d_req_addr  = ($urandom_range(0, 1) == 1 ? 8'h10 : 8'h90) + 8'($urandom_range(0, 7));
        bus.d_req_wdata = 8'($urandom);
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      RESET = ($urandom_range(0, 199) == 0);
      step();
    end
    RESET = 1'b0;
    bus.if_req_valid = 1'b0;
    bus.d_req_valid  = 1'b0;
    bus.rsp_ready    = 1'b1;
    for (int i = 0; i < 6; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory access controller sitting directly upstream of the program/data memory (ROM region below `ROM_SIZE`, RAM above). It arbitrates between the instruction-fetch port and the data load/store port and sequences one memory transaction at a time onto the memory's CS/WE/addr/data pins. It captures the memory's read data and ERROR flag and returns them as a registered response with valid/ready handshake. It also keeps a saturating count of memory errors.

## Interface
Parameters:
- ADDR_BITS, 8, memory address width
- DATA_BITS, 8, memory data width
- ROM_SIZE, 128, first writable address; used only for the rsp_err cross-check in test, not for gating

Ports:
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  synchronous, active-high reset
- if_req_valid  in  1  fetch request
- if_req_addr  in  ADDR_BITS  fetch address
- if_req_ready  out  1  fetch request accepted this cycle
- d_req_valid  in  1  data request
- d_req_we  in  1  1 = store, 0 = load
- d_req_addr  in  ADDR_BITS  data address
- d_req_wdata  in  DATA_BITS  store data
- d_req_ready  out  1  data request accepted this cycle
- rsp_valid  out  1  response held valid
- rsp_ready  in  1  consumer takes response
- rsp_src  out  1  0 = fetch, 1 = data
- rsp_rdata  out  DATA_BITS  read data (0 for stores)
- rsp_err  out  1  memory ERROR captured for this transaction
- mem_cs  out  1  memory chip select
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_BITS  memory address
- mem_wdata  out  DATA_BITS  memory write data
- mem_rdata  in  DATA_BITS  memory read data
- mem_err  in  1  memory ERROR
- err_cnt  out  8  saturating count of transactions with rsp_err = 1

## Operation
- States: IDLE, ISSUE, WAIT, RESP. One outstanding transaction.
- IDLE: ready asserted only to the granted port, combinationally. Valid inputs must not depend on ready.
  - One requester valid: grant it.
  - Both valid: round-robin. The port not granted last time wins. The pointer resets to favour fetch.
  - On handshake, register addr/we/wdata/src into mem_* regs and go to ISSUE.
- ISSUE: mem_cs = 1. mem_we = d_req_we for data, 0 for fetch. The memory performs the access at the edge ending ISSUE. Next state is WAIT.
- WAIT: mem_cs = 0, mem_we = 0. mem_rdata and mem_err are now stable.
  - At the edge ending WAIT, capture rsp_rdata (mem_rdata for loads/fetches, 0 for stores), rsp_err = mem_err, and rsp_src.
  - Increment err_cnt if mem_err (saturates at 255). Go to RESP.
- RESP: rsp_valid = 1 with all rsp_* held stable until rsp_ready = 1. Return to IDLE on the handshake edge. No request is accepted in RESP.
- mem_addr/mem_wdata hold their last value outside ISSUE. Only mem_cs qualifies them.
- The memory flags writes to addresses < ROM_SIZE. The controller forwards that flag only and does not block the write itself.

## Timing
- Reset values (sync, at first edge with RESET = 1):
  - state = IDLE, rsp_valid = 0, rsp_src = 0, rsp_rdata = 0, rsp_err = 0
  - mem_cs = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0
  - err_cnt = 0, round-robin pointer favours fetch
- if_req_ready and d_req_ready are 0 while RESET is high.
- Request accepted at edge E0 → mem_cs high E0–E1 → memory acts at E1 → capture at E2 → rsp_valid high from E2.
- Minimum 4 cycles per transaction when rsp_ready is held high (accept, ISSUE, WAIT, RESP).
- RESET mid-transaction: the transaction is dropped with no response and no err_cnt update. If asserted during ISSUE, mem_cs is 0 from the next cycle. The controller does not drive the memory's own reset.
- Simultaneous valid with the same port in both cycles alternates grants F, D, F, D.
- A held, un-granted request stays pending. The bench requires its addr/data to remain stable until ready.

## Test plan
- Fetch of addr 0x05 after RESET (memory preloaded with 0xA5 at 5) → mem_cs pulses one cycle with mem_we = 0, mem_addr = 0x05; rsp_valid two edges later with rsp_src = 0, rsp_rdata = 0xA5, rsp_err = 0.
- Data store 0x3C to 0x90, then load 0x90 → first rsp: rsp_src = 1, rsp_rdata = 0, rsp_err = 0; second rsp: rsp_rdata = 0x3C.
- Data store to 0x10 (ROM) → rsp_err = 1, err_cnt 0→1; a subsequent load of 0x10 returns the original ROM byte.
- Both ports valid continuously for 4 transactions with rsp_ready = 1 → grants F, D, F, D; each response arrives 4 cycles after the previous one.
- rsp_ready held low 5 cycles in RESP → rsp_* stable, both req_ready = 0, mem_cs = 0 throughout; completes on the first rsp_ready = 1.
- RESET asserted during ISSUE of a store → no rsp_valid, err_cnt = 0, mem_cs = 0 next cycle; a fetch issued after reset completes normally. Also drive 256 ROM writes → err_cnt saturates at 255.
